mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (fetch / data) arbiter in front of a single-port RAM.
// Data has priority over fetch. A stall counter bounds how many times in a row
// fetch can lose. Each access takes an ISSUE cycle (gnt + RAM strobe) followed
// by a RESP cycle (valid + read data).
// Ports:
//   clock, rst                      clock and synchronous active-high reset
//   i_req/i_address                 fetch request; i_gnt/i_valid/i_rdata responses
//   d_req/d_we/d_address/d_wdata    data request; d_gnt/d_valid/d_rdata/d_err responses
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata   single-port RAM, 1-cycle read latency
module mem_arbiter #(
  parameter logic [31:0] START_ADDRESS = 32'h0000_0000,
  parameter int unsigned MEM_SIZE      = 65536,
  parameter int unsigned MAX_STALL     = 4
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_address,
  output logic        i_gnt,
  output logic        i_valid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic [3:0]  d_we,
  input  logic [31:0] d_address,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_valid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_en,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned DW = 32;
  localparam int unsigned SW = 3;
  localparam logic [DW-1:0] LAST_OFFSET = DW'(MEM_SIZE - 4);
  localparam logic [SW-1:0] STALL_LIMIT = SW'(MAX_STALL);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   stall_cnt_q, stall_cnt_d;
  logic            win_data_q, win_data_d;
  logic            in_range_q, in_range_d;
  logic            i_gnt_q, i_gnt_d, d_gnt_q, d_gnt_d;
  logic            i_valid_q, i_valid_d, d_valid_q, d_valid_d;
  logic            d_err_q, d_err_d;
  logic            mem_en_q, mem_en_d;
  logic [3:0]      mem_we_q, mem_we_d;
  logic [DW-1:0]   mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [DW-1:0]   i_hold_q, i_hold_d, d_hold_q, d_hold_d;

  logic            pick_data;
  logic [DW-1:0]   win_addr, win_off;
  logic            win_write, win_in_range;

  // Winner selection and range check of the candidate payload
  always_comb begin
    if (i_req && d_req) pick_data = (stall_cnt_q != STALL_LIMIT);
    else                pick_data = d_req;
    win_addr     = pick_data ? d_address : i_address;
    win_off      = win_addr - START_ADDRESS;
    win_write    = pick_data && (d_we != 4'b0000);
    // Writes into the upper half of the address space are never allowed.
    win_in_range = (win_off <= LAST_OFFSET) && !(win_write && win_addr[31]);
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    win_data_d  = win_data_q;
    in_range_d  = in_range_q;
    i_gnt_d     = 1'b0;
    d_gnt_d     = 1'b0;
    i_valid_d   = 1'b0;
    d_valid_d   = 1'b0;
    d_err_d     = 1'b0;
    mem_en_d    = 1'b0;
    mem_we_d    = 4'b0000;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_hold_d    = i_rdata;
    d_hold_d    = d_rdata;

    case (state_q)
      IDLE, RESP: begin
        if (i_req || d_req) begin
          state_d    = ISSUE;
          win_data_d = pick_data;
          in_range_d = win_in_range;
          i_gnt_d    = !pick_data;
          d_gnt_d    = pick_data;
          mem_en_d   = win_in_range;
          mem_we_d   = (win_in_range && pick_data) ? d_we : 4'b0000;
          mem_addr_d = win_off;
          if (pick_data) mem_wdata_d = d_wdata;
          // Only a data win over a waiting fetch counts as a fetch loss.
          if (!pick_data)  stall_cnt_d = '0;
          else if (i_req)  stall_cnt_d = stall_cnt_q + SW'(1);
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        state_d   = RESP;
        i_valid_d = !win_data_q;
        d_valid_d = win_data_q;
        d_err_d   = win_data_q && !in_range_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // RAM data arrives during RESP, so the response word bypasses the hold register.
  always_comb begin
    i_rdata = i_hold_q;
    d_rdata = d_hold_q;
    if (state_q == RESP) begin
      if (win_data_q) d_rdata = in_range_q ? mem_rdata : '0;
      else            i_rdata = in_range_q ? mem_rdata : '0;
    end
  end

  // State and output registers
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q     <= IDLE;
      stall_cnt_q <= '0;
      win_data_q  <= 1'b0;
      in_range_q  <= 1'b0;
      i_gnt_q     <= 1'b0;
      d_gnt_q     <= 1'b0;
      i_valid_q   <= 1'b0;
      d_valid_q   <= 1'b0;
      d_err_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 4'b0000;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_hold_q    <= '0;
      d_hold_q    <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      win_data_q  <= win_data_d;
      in_range_q  <= in_range_d;
      i_gnt_q     <= i_gnt_d;
      d_gnt_q     <= d_gnt_d;
      i_valid_q   <= i_valid_d;
      d_valid_q   <= d_valid_d;
      d_err_q     <= d_err_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_hold_q    <= i_hold_d;
      d_hold_q    <= d_hold_d;
    end
  end

  assign i_gnt     = i_gnt_q;
  assign d_gnt     = d_gnt_q;
  assign i_valid   = i_valid_q;
  assign d_valid   = d_valid_q;
  assign d_err     = d_err_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios plus randomized traffic against
// a transaction-level reference model and a behavioural single-port RAM.
module tb_mem_arbiter;

  localparam logic [31:0] START  = 32'h7FFF_FF80;
  localparam int unsigned MSIZE  = 256;
  localparam int unsigned MSTALL = 4;
  localparam int unsigned WORDS  = MSIZE / 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_address = '0;
  logic        i_gnt, i_valid;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0;
  logic [3:0]  d_we = '0;
  logic [31:0] d_address = '0, d_wdata = '0;
  logic        d_gnt, d_valid, d_err;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;

  always #5 clk = ~clk;

  mem_arbiter #(.START_ADDRESS(START), .MEM_SIZE(MSIZE), .MAX_STALL(MSTALL)) dut (
    .clock(clk), .rst(rst),
    .i_req(i_req), .i_address(i_address), .i_gnt(i_gnt), .i_valid(i_valid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_address(d_address), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] init_word(int unsigned k);
    return 32'(k * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  // Behavioural RAM: read-before-write, data one cycle after mem_en
  logic [31:0] ram [WORDS];
  logic        ram_loaded = 1'b0;
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int k = 0; k < int'(WORDS); k++) ram[k] <= init_word(k);
      ram_loaded <= 1'b1;
    end else if (mem_en) begin
      for (int k = 0; k < 4; k++)
        if (mem_we[k]) ram[mem_addr[7:2]][8*k +: 8] <= mem_wdata[8*k +: 8];
      mem_rdata <= ram[mem_addr[7:2]];
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [31:0] ref_mem [WORDS];
  int          losses;
  bit          m_busy;
  bit          f_isd, f_inr;
  logic [31:0] f_rdata;
  logic [31:0] exp_irdata, exp_drdata;
  bit          e_igt, e_dgt, e_iv, e_dv, e_err, e_en, e_wr, e_rst;
  logic [3:0]  e_we;
  logic [31:0] e_addr, e_wdata;
  logic [31:0] order_bits;
  int          n_gnt, last_gnt_cyc, cyc;

  // Predict what the cycle after the coming edge must show, from sampled inputs
  task automatic model_edge();
    bit both, pick_d, isw;
    logic [31:0] addr, off;
    e_igt = 0; e_dgt = 0; e_iv = 0; e_dv = 0; e_err = 0; e_en = 0; e_wr = 0; e_rst = 0;
    e_we = '0; e_addr = '0; e_wdata = '0;
    if (rst) begin
      losses = 0; m_busy = 0; exp_irdata = '0; exp_drdata = '0; e_rst = 1;
      return;
    end
    if (m_busy) begin
      m_busy = 0;
      if (f_isd) begin e_dv = 1; e_err = !f_inr; exp_drdata = f_inr ? f_rdata : '0; end
      else       begin e_iv = 1; exp_irdata = f_inr ? f_rdata : '0; end
    end else if (i_req || d_req) begin
      both   = i_req && d_req;
      pick_d = both ? (losses != int'(MSTALL)) : d_req;
      if (!pick_d) losses = 0;
      else if (both) losses++;
      addr  = pick_d ? d_address : i_address;
      off   = addr - START;
      isw   = pick_d && (d_we != 0);
      f_isd = pick_d;
      f_inr = (off <= 32'(MSIZE - 4)) && !(isw && addr[31]);
      e_igt = !pick_d; e_dgt = pick_d;
      e_en  = f_inr;
      if (f_inr) begin
        f_rdata = ref_mem[off[7:2]];
        e_addr  = off;
        e_we    = isw ? d_we : 4'b0000;
        e_wr    = isw;
        e_wdata = d_wdata;
        for (int k = 0; k < 4; k++)
          if (isw && d_we[k]) ref_mem[off[7:2]][8*k +: 8] = d_wdata[8*k +: 8];
      end
      m_busy = 1;
    end
  endtask

  task automatic check_cycle();
    check_eq("i_gnt", 32'(i_gnt), 32'(e_igt));
    check_eq("d_gnt", 32'(d_gnt), 32'(e_dgt));
    check_eq("i_valid", 32'(i_valid), 32'(e_iv));
    check_eq("d_valid", 32'(d_valid), 32'(e_dv));
    check_eq("mem_en", 32'(mem_en), 32'(e_en));
    if (e_en) begin
      check_eq("mem_addr", mem_addr, e_addr);
      check_eq("mem_we", 32'(mem_we), 32'(e_we));
      if (e_wr) check_eq("mem_wdata", mem_wdata, e_wdata);
    end else if (!(e_igt || e_dgt)) begin
      check_eq("mem_we_idle", 32'(mem_we), 32'h0);
    end
    if (e_dv) check_eq("d_err", 32'(d_err), 32'(e_err));
    check_eq("i_rdata", i_rdata, exp_irdata);
    check_eq("d_rdata", d_rdata, exp_drdata);
    if (e_rst) begin
      check_eq("rst_mem_addr", mem_addr, 32'h0);
      check_eq("rst_mem_wdata", mem_wdata, 32'h0);
      check_eq("rst_d_err", 32'(d_err), 32'h0);
    end
    if (i_gnt || d_gnt) begin
      order_bits = {order_bits[30:0], d_gnt};
      n_gnt++;
      last_gnt_cyc = cyc;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    check_cycle();
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 7))
      0:       return START + 32'(MSIZE - 4);
      1:       return START + 32'(MSIZE - 3) + 32'($urandom_range(0, 8));
      2:       return START - 32'($urandom_range(1, 16));
      3:       return 32'($urandom);
      default: return START + 32'($urandom_range(0, MSIZE - 4));
    endcase
  endfunction

  task automatic drive_random();
    if (i_req && i_gnt) i_req = 0;
    else if (i_req && $urandom_range(0, 99) < 8) i_req = 0;
    if (!i_req && $urandom_range(0, 99) < 45) begin
      i_req = 1; i_address = rand_addr();
    end
    if (d_req && d_gnt) d_req = 0;
    else if (d_req && $urandom_range(0, 99) < 8) d_req = 0;
    if (!d_req && $urandom_range(0, 99) < 55) begin
      d_req = 1; d_address = rand_addr(); d_wdata = $urandom;
      d_we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
    end
  endtask

  // Present one data request, wait (bounded) for its grant, then its response
  task automatic serve_d(input logic [31:0] addr, input logic [3:0] we,
                         input logic [31:0] wdata, input string tag);
    int n;
    d_req = 1; d_address = addr; d_we = we; d_wdata = wdata;
    n = 0;
    do begin step(); n++; end while (!d_gnt && n < 8);
    if (!d_gnt) check_eq({tag, "_gnt_timeout"}, 32'(d_gnt), 32'h1);
    check_eq({tag, "_mem_en"}, 32'(mem_en), 32'(e_en));
    d_req = 0;
    step();
    check_eq({tag, "_d_valid"}, 32'(d_valid), 32'h1);
  endtask

  task automatic do_reset();
    rst = 1; i_req = 0; d_req = 0;
    step(); step();
    rst = 0;
  endtask

  initial begin
    for (int k = 0; k < int'(WORDS); k++) ref_mem[k] = init_word(k);
    losses = 0; m_busy = 0; exp_irdata = '0; exp_drdata = '0;
    order_bits = '0; n_gnt = 0; last_gnt_cyc = 0; cyc = 0;

    do_reset();

    // Single fetch at offset 8: gnt+strobe next cycle, response the cycle after
    i_req = 1; i_address = START + 32'd8;
    step();
    check_eq("fetch_gnt", 32'(i_gnt), 32'h1);
    check_eq("fetch_addr", mem_addr, 32'd8);
    check_eq("fetch_we", 32'(mem_we), 32'h0);
    i_req = 0;
    step();
    check_eq("fetch_valid", 32'(i_valid), 32'h1);
    check_eq("fetch_rdata", i_rdata, init_word(2));
    step();

    // Partial write, then out-of-range write, then offset boundary
    serve_d(START + 32'd4, 4'b0011, 32'hAABB_CCDD, "wr");
    check_eq("wr_err", 32'(d_err), 32'h0);
    serve_d(32'h8000_0000, 4'hF, 32'h1234_5678, "oor");
    check_eq("oor_err", 32'(d_err), 32'h1);
    check_eq("oor_rdata", d_rdata, 32'h0);
    serve_d(START + 32'(MSIZE - 4), 4'h0, '0, "bnd_ok");
    check_eq("bnd_ok_err", 32'(d_err), 32'h0);
    serve_d(START + 32'(MSIZE - 3), 4'h0, '0, "bnd_bad");
    check_eq("bnd_bad_err", 32'(d_err), 32'h1);
    step();

    // Both requesters always pending: fetch wins every fifth grant
    do_reset();
    order_bits = '0; n_gnt = 0;
    i_req = 1; i_address = START;
    d_req = 1; d_address = START + 32'd16; d_we = 4'h0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (i_gnt) i_address = START + 32'($urandom_range(0, WORDS - 1) * 4);
      if (d_gnt) d_address = START + 32'($urandom_range(0, WORDS - 1) * 4);
    end
    check_eq("starve_order", order_bits & 32'h3FF, 32'h3DE);
    check_eq("starve_gnt_count", 32'(n_gnt), 32'd10);
    i_req = 0; d_req = 0;
    step(); step();

    // Reset while the access is in ISSUE: it must never respond
    d_req = 1; d_address = START + 32'd20; d_we = 4'h0;
    begin
      int n = 0;
      do begin step(); n++; end while (!d_gnt && n < 8);
      check_eq("rst_mid_gnt", 32'(d_gnt), 32'h1);
    end
    d_req = 0; rst = 1;
    step();
    rst = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      check_eq("rst_mid_no_valid", 32'(d_valid | i_valid), 32'h0);
    end
    i_req = 1; i_address = START + 32'd12;
    step();
    check_eq("rst_then_gnt", 32'(i_gnt), 32'h1);
    i_req = 0;
    step();
    check_eq("rst_then_valid", 32'(i_valid), 32'h1);

    // Randomized traffic, including withdrawals and occasional resets
    for (int c = 0; c < 3000; c++) begin
      step();
      if (rst) rst = 0;
      else if ($urandom_range(0, 399) == 0) rst = 1;
      if (rst) begin i_req = 0; d_req = 0; end
      else drive_random();
    end
    i_req = 0; d_req = 0;
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
